// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_tx_shifter.sv
// Holds the word being serialized (LSB presented on ser_bit) and the parity bit
// computed from it when the word is loaded.
module uart_tx_shifter
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  parity_type,
  output logic                  ser_bit,
  output logic                  parity_bit
);

  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg <= '0;
      parity_q  <= 1'b0;
    end else if (load) begin
      shift_reg <= data_in;
      parity_q  <= (^data_in) ^ (parity_type == PARITY_ODD);
    end else if (shift) begin
      shift_reg <= shift_reg >> 1;
    end
  end

  assign ser_bit    = shift_reg[0];
  assign parity_bit = parity_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word intake, start/data/parity/stop framing,
// per-bit timing from an internal clock counter.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  parity_en,
  input  logic                  parity_type,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  tx_out
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready is a pure decode of the registered state.
  tx_state_t        state, state_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic             stop_cnt;
  logic             parity_en_q;
  logic             load, shift, bit_done, last_data, last_stop;
  logic             ser_bit, parity_bit;

  uart_tx_shifter #(.DATA_WIDTH(DATA_WIDTH)) u_shifter (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .shift       (shift),
    .data_in     (tx_data),
    .parity_type (parity_type),
    .ser_bit     (ser_bit),
    .parity_bit  (parity_bit)
  );

  assign bit_done  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_data = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    shift      = 1'b0;
    tx_out     = IDLE_LEVEL;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        tx_out = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        tx_out = ser_bit;
        if (bit_done) begin
          shift = 1'b1;
          if (last_data) state_next = parity_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_out = parity_bit;
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        if (bit_done && last_stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Counters restart on every state change so each state times itself from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_cnt     <= '0;
      bit_idx     <= '0;
      stop_cnt    <= 1'b0;
      parity_en_q <= 1'b0;
    end else begin
      if (load) parity_en_q <= parity_en;
      if (state_next != state) begin
        clk_cnt  <= '0;
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
      end else if (state != IDLE) begin
        clk_cnt <= bit_done ? '0 : clk_cnt + 1'b1;
        if (bit_done && state == DATA) bit_idx  <= bit_idx + 1'b1;
        if (bit_done && state == STOP) stop_cnt <= stop_cnt + 1'b1;
      end
    end
  end

  assign tx_ready = (state == IDLE);
  assign busy     = !tx_ready;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames plus randomized traffic against a
// bit-list frame model; a second instance covers two stop bits.
module tb_uart_tx;

  localparam int CPB = 4;
  localparam int DW  = 8;

  logic       clk;
  logic       reset;
  logic [1:0] tx_valid;
  logic [7:0] tx_data;
  logic       parity_en;
  logic       parity_type;
  logic [1:0] tx_ready, busy, tx_out;

  int n_checks = 0;
  int n_pass   = 0;
  logic exp_q[$];

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid[0]), .tx_data(tx_data),
    .parity_en(parity_en), .parity_type(parity_type),
    .tx_ready(tx_ready[0]), .busy(busy[0]), .tx_out(tx_out[0])
  );

  uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tx_valid(tx_valid[1]), .tx_data(tx_data),
    .parity_en(parity_en), .parity_type(parity_type),
    .tx_ready(tx_ready[1]), .busy(busy[1]), .tx_out(tx_out[1])
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: the frame as a list of line levels, one entry per clock.
  task automatic build_frame(input logic [7:0] data, input logic pen, input logic ptype,
                             input int stops);
    int ones;
    logic bits[$];
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) begin
      bits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pen) bits.push_back(ptype ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1));
    for (int i = 0; i < stops; i++) bits.push_back(1'b1);
    exp_q.delete();
    foreach (bits[b]) for (int c = 0; c < CPB; c++) exp_q.push_back(bits[b]);
  endtask

  // driver: present a word at a negedge while the selected DUT should be idle
  task automatic present(input int sel, input logic [7:0] data, input logic pen, input logic ptype);
    check($sformatf("ready_before[%0d]", sel), 32'(tx_ready[sel]), 32'd1);
    tx_data     = data;
    parity_en   = pen;
    parity_type = ptype;
    tx_valid    = '0;
    tx_valid[sel] = 1'b1;
  endtask

  // Follows one frame cycle by cycle; inputs are scrambled while busy, and on
  // the last frame cycle the optional follow-on word is placed on the inputs.
  task automatic expect_frame(input int sel, input logic [7:0] data, input logic pen,
                              input logic ptype, input bit chain, input logic [7:0] nd,
                              input logic npen, input logic nptype);
    int n, busy_cnt;
    build_frame(data, pen, ptype, sel + 1);
    n = exp_q.size();
    busy_cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check($sformatf("line[%0d] d=%02h bit%0d", sel, data, k / CPB), 32'(tx_out[sel]),
            32'(exp_q.pop_front()));
      if (busy[sel]) busy_cnt++;
      if (k == n - 1) begin
        tx_data = nd; parity_en = npen; parity_type = nptype;
        tx_valid = '0;
        tx_valid[sel] = chain;
      end else begin
        tx_data = 8'($urandom); parity_en = 1'($urandom); parity_type = 1'($urandom);
        tx_valid = '0;
        tx_valid[sel] = 1'($urandom);
      end
    end
    check($sformatf("frame_len[%0d] d=%02h", sel, data), 32'(busy_cnt),
          32'(CPB * (1 + DW + int'(pen) + sel + 1)));
    @(negedge clk);
    check($sformatf("idle_ready[%0d]", sel), 32'(tx_ready[sel]), 32'd1);
    check($sformatf("idle_line[%0d]", sel), 32'(tx_out[sel]), 32'd1);
  endtask

  task automatic send(input int sel, input logic [7:0] data, input logic pen, input logic ptype);
    @(negedge clk);
    present(sel, data, pen, ptype);
    expect_frame(sel, data, pen, ptype, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] cur_d, nxt_d;
    logic cur_p, cur_t, nxt_p, nxt_t;
    bit ch;

    reset = 1'b0; tx_valid = '0; tx_data = '0; parity_en = 1'b0; parity_type = 1'b0;

    // reset held for 3 clocks
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_line", 32'(tx_out), 32'h3);
      check("rst_ready", 32'(tx_ready), 32'h3);
      check("rst_busy", 32'(busy), 32'h0);
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post_rst_line", 32'(tx_out), 32'h3);
      check("post_rst_busy", 32'(busy), 32'h0);
    end

    // plain frame and both parity senses
    send(0, 8'hA5, 1'b0, 1'b0);
    send(0, 8'h07, 1'b1, 1'b0);
    send(0, 8'h07, 1'b1, 1'b1);

    // back-to-back: second word waits on the inputs and is taken on the idle cycle
    @(negedge clk);
    present(0, 8'h55, 1'b0, 1'b0);
    expect_frame(0, 8'h55, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    expect_frame(0, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // reset in the middle of data bit 3 aborts the frame
    @(negedge clk);
    present(0, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    tx_valid = '0;
    repeat (16) @(negedge clk);
    check("mid_busy", 32'(busy[0]), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_line", 32'(tx_out[0]), 32'd1);
    check("abort_ready", 32'(tx_ready[0]), 32'd1);
    check("abort_busy", 32'(busy[0]), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_resume", 32'(tx_out[0]), 32'd1);
    end
    send(0, 8'h3C, 1'b0, 1'b0);

    // two stop bits with odd parity
    send(1, 8'h00, 1'b1, 1'b1);

    // randomized traffic with random back-to-back chaining
    cur_d = 8'($urandom); cur_p = 1'($urandom); cur_t = 1'($urandom);
    @(negedge clk);
    present(0, cur_d, cur_p, cur_t);
    for (int i = 0; i < 24; i++) begin
      nxt_d = 8'($urandom); nxt_p = 1'($urandom); nxt_t = 1'($urandom);
      ch = (i != 23) && ($urandom_range(0, 1) == 1);
      expect_frame(0, cur_d, cur_p, cur_t, ch, nxt_d, nxt_p, nxt_t);
      if (!ch && i != 23) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        present(0, nxt_d, nxt_p, nxt_t);
      end
      cur_d = nxt_d; cur_p = nxt_p; cur_t = nxt_t;
    end

    for (int i = 0; i < 4; i++)
      send(1, 8'($urandom), 1'($urandom), 1'($urandom));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter: the transmit-side counterpart of the receive path.
- Accepts one parallel word per valid/ready handshake.
- Serializes it LSB-first onto a single line: start bit, DATA_WIDTH data bits, optional parity bit, STOP_BITS stop bits.
- Bit timing comes from an internal per-bit clock counter.
- Sits between the host-side register/FIFO interface and the TX pad.

Parameters:
- DATA_WIDTH, 8: parallel word width, in bits.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be >= 2.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low.
- tx_valid  input  1  host presents a word on tx_data.
- tx_data  input  DATA_WIDTH  word to transmit.
- parity_en  input  1  1 = append a parity bit.
- parity_type  input  1  0 = even, 1 = odd.
- tx_ready  output  1  block can accept a word this cycle.
- busy  output  1  a frame is in progress.
- tx_out  output  1  serial line; idle level is 1.

Behaviour:
- Reset (async, reset=0): state=IDLE, tx_out=1, busy=0, tx_ready=1. All counters and the shift register clear to 0.
- tx_ready = (state==IDLE); busy = !tx_ready. Both are registered-state decodes; no combinational path from tx_valid.
- Accept: at a rising edge with tx_valid && tx_ready:
  - latch tx_data, parity_en, parity_type;
  - compute parity = ^tx_data ^ parity_type;
  - go to START.
- Changes to inputs after accept have no effect on the current frame.
- tx_valid while busy is ignored; no data is captured.
- States:
  - IDLE: tx_out=1.
  - START: tx_out=0.
  - DATA: tx_out=shift_reg[0]; shift right once per bit.
  - PARITY: tx_out=latched parity.
  - STOP: tx_out=1.
- Each non-IDLE state holds tx_out for CLKS_PER_BIT cycles, timed by clk_cnt (0..CLKS_PER_BIT-1).
- Transition rules:
  - START -> DATA.
  - DATA repeats until bit_idx==DATA_WIDTH-1, then -> PARITY if parity_en, else -> STOP.
  - PARITY -> STOP.
  - STOP repeats STOP_BITS times, then -> IDLE.
- Latency: tx_out falls on the cycle after the accept edge.
- Frame length = CLKS_PER_BIT*(1+DATA_WIDTH+parity_en+STOP_BITS) clocks, from the first low cycle to the first IDLE cycle.
- Counter widths:
  - clk_cnt: $clog2(CLKS_PER_BIT) bits.
  - bit_idx: $clog2(DATA_WIDTH) bits, wide enough to hold DATA_WIDTH-1.
  - stop counter: 1 bit.
- Counters reset to 0 on every state transition; no wrap beyond the terminal values.
- Back-to-back: IDLE lasts at least one cycle between frames. A word presented on that IDLE cycle is accepted there, so the minimum inter-frame line-high gap is STOP_BITS*CLKS_PER_BIT+1 cycles.
- Reset mid-frame aborts immediately: tx_out=1 and IDLE. No partial frame resumes.
- Parity/config inputs are sampled only at accept.

Decomposition:
- Package uart_pkg holds:
  - tx state enum (IDLE, START, DATA, PARITY, STOP);
  - constants PARITY_EVEN=1'b0, PARITY_ODD=1'b1;
  - IDLE_LEVEL=1'b1.
- One natural sub-module, uart_tx_shifter:
  - load/shift register plus parity computation;
  - ports clk, reset, load, shift, data_in, parity_type, ser_bit, parity_bit.
- The FSM and bit timer stay in uart_tx.

Test Plan (CLKS_PER_BIT=4, DATA_WIDTH=8, STOP_BITS=1 unless noted):
1. Reset: hold reset=0 for 3 clk, release -> tx_out=1, tx_ready=1, busy=0 throughout and after.
2. tx_data=0xA5, parity_en=0, pulse tx_valid -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 clk (40 clk frame), then tx_ready=1.
3. tx_data=0x07, parity_en=1, parity_type=0 -> parity bit=1. Repeat with parity_type=1 -> parity bit=0. Frame length 44 clk.
4. Hold tx_valid high with 0x55 then 0xAA queued:
   - second word accepted on the single IDLE cycle;
   - tx_valid pulses with new tx_data during busy are ignored;
   - the two frames are exactly 0x55 then 0xAA.
5. Assert reset during data bit 3 of 0xFF -> tx_out=1 asynchronously, state IDLE. Next word 0x3C transmits a clean full frame.
6. STOP_BITS=2, tx_data=0x00, parity_en=1, parity_type=1 -> parity bit=1, stop high for 8 clk, frame length 48 clk.
